// File: rtl/mem_arb_pkg.sv
// Shared types for the cpu2 main-memory fill arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Default block geometry; the word-index width follows from it.
  localparam int BLK_WORDS_DFLT = 8;
  localparam int IDX_W          = $clog2(BLK_WORDS_DFLT);

endpackage

// File: rtl/mem_rd_tracker.sv
// Tracks outstanding memory reads so the returning word can be flagged.
// Latency: ret_valid rises exactly MEM_LAT cycles after issue.
// Backpressure: none; one issue per cycle always accepted.
module mem_rd_tracker #(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic ret_valid
);

  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] vld_d;

  // Shift a marker in for every read issued this cycle.
  always_comb begin
    vld_d = (vld_q << 1) | MEM_LAT'(issue);
  end

  // Pipeline register; clearing it drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign ret_valid = vld_q[MEM_LAT-1];

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the single-ported main memory between I-fill and D-fill/write.
// Latency: grant 1 cycle after request in IDLE; fill words MEM_LAT after each issue.
// Backpressure: requesters hold req until done; no preemption once granted.
module mem_fill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int BLK_WORDS  = BLK_WORDS_DFLT,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_data_valid,
  output logic [DATA_W-1:0]            i_data,
  output logic [$clog2(BLK_WORDS)-1:0] i_word_idx,
  output logic                         i_done,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_data_valid,
  output logic [DATA_W-1:0]            d_data,
  output logic [$clog2(BLK_WORDS)-1:0] d_word_idx,
  output logic                         d_done,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int                IW         = $clog2(BLK_WORDS);
  localparam int                SW         = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] BLK_MASK   = ~ADDR_W'(BLK_WORDS - 1);
  localparam logic [IW-1:0]     LAST_IDX   = IW'(BLK_WORDS - 1);
  localparam logic [SW-1:0]     STARVE_TOP = SW'(STARVE_MAX);

  arb_state_e        state_q,  state_d;
  owner_e            owner_q,  owner_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [IW:0]       iss_q,    iss_d;     // top bit set once all words issued
  logic [IW-1:0]     ret_q,    ret_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic in_fill;
  logic issue;
  logic ret_valid;
  logic ret_last;
  logic i_wins;

  assign in_fill  = (state_q == I_FILL) || (state_q == D_FILL);
  assign issue    = in_fill && !iss_q[IW];
  assign ret_last = ret_valid && (ret_q == LAST_IDX);
  // D has priority unless I has already been passed over STARVE_MAX times.
  assign i_wins   = i_req && (!d_req || (starve_q == STARVE_TOP));

  mem_rd_tracker #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_tracker (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .ret_valid (ret_valid)
  );

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      addr_q   <= '0;
      wdata_q  <= '0;
      iss_q    <= '0;
      ret_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      iss_q    <= iss_d;
      ret_q    <= ret_d;
      starve_q <= starve_d;
    end
  end

  // Next-state: grant in IDLE, count issues/returns while filling.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    iss_d    = iss_q;
    ret_d    = ret_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        iss_d = '0;
        ret_d = '0;
        if (i_wins) begin
          state_d  = I_FILL;
          owner_d  = OWN_I;
          addr_d   = i_addr & BLK_MASK;
          starve_d = '0;
        end else if (d_req) begin
          owner_d  = OWN_D;
          wdata_d  = d_wdata;
          state_d  = d_we ? D_WRITE : D_FILL;
          addr_d   = d_we ? d_addr : (d_addr & BLK_MASK);
          if (!i_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_TOP) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      I_FILL, D_FILL: begin
        if (issue) begin
          iss_d = iss_q + (IW+1)'(1);
        end
        if (ret_valid) begin
          ret_d = ret_q + IW'(1);
        end
        if (ret_last) begin
          state_d = IDLE;
        end
      end
      D_WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: memory command plus return routing to the current owner.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_word_idx   = '0;
    i_done       = 1'b0;
    d_data_valid = 1'b0;
    d_data       = '0;
    d_word_idx   = '0;
    d_done       = 1'b0;
    if (!rst) begin
      if (issue) begin
        mem_en   = 1'b1;
        mem_addr = addr_q + ADDR_W'(iss_q[IW-1:0]);
      end
      if (state_q == D_WRITE) begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_done    = 1'b1;
      end
      if (in_fill && ret_valid) begin
        if (owner_q == OWN_I) begin
          i_data_valid = 1'b1;
          i_data       = mem_rdata;
          i_word_idx   = ret_q;
          i_done       = ret_last;
        end else begin
          d_data_valid = 1'b1;
          d_data       = mem_rdata;
          d_word_idx   = ret_q;
          d_done       = ret_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_fill_arbiter;

  localparam int BLK  = 8;
  localparam int LAT  = 4;
  localparam int SMAX = 2;

  logic        clk, rst;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_data_valid, i_done, d_data_valid, d_done;
  logic [15:0] i_data, d_data, mem_addr, mem_wdata;
  logic [2:0]  i_word_idx, d_word_idx;
  logic        mem_en, mem_wr;

  mem_fill_arbiter #(
    .ADDR_W(16), .DATA_W(16), .BLK_WORDS(BLK), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data_valid(i_data_valid), .i_data(i_data),
    .i_word_idx(i_word_idx), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_data_valid(d_data_valid), .d_data(d_data), .d_word_idx(d_word_idx), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int cycle = 0;

  // memory environment
  logic [15:0] mem_a [int];
  logic        pipe_v [LAT];
  logic [15:0] pipe_a [LAT];

  // reference model state
  bit          m_busy = 0, m_wr = 0, m_own = 0;
  int          m_off = 0, m_starve = 0;
  logic [15:0] m_base = 0, m_wdata = 0;

  // requester state and observations
  int  i_left = 0, d_left = 0;
  bit  rnd = 0;
  byte order_q[$];
  logic        obs_en, obs_wr, obs_iv, obs_dv, obs_idone, obs_ddone;
  logic [15:0] obs_addr, obs_wdata;
  logic [2:0]  obs_iidx, obs_didx;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem_a.exists(int'(a))) return mem_a[int'(a)];
    return 16'(int'(a) * 40503) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cycle, act, exp);
    end
  endtask

  // One clock cycle: compare against the model mid-cycle, advance model and memory.
  task automatic cyc();
    logic        e_en, e_wr, e_iv, e_dv, e_id, e_dd;
    logic [15:0] e_addr, e_wdata, e_data;
    int          idx;
    @(negedge clk);
    e_en = 0; e_wr = 0; e_iv = 0; e_dv = 0; e_id = 0; e_dd = 0;
    e_addr = 0; e_wdata = 0; e_data = 0; idx = 0;
    if (!rst && m_busy) begin
      if (m_wr) begin
        e_en = 1; e_wr = 1; e_addr = m_base; e_wdata = m_wdata; e_dd = 1;
      end else begin
        if (m_off < BLK) begin
          e_en = 1;
          e_addr = m_base + 16'(m_off);
        end
        if (m_off >= LAT && m_off < LAT + BLK) begin
          idx = m_off - LAT;
          e_data = mem_rd(m_base + 16'(idx));
          if (m_own) begin e_dv = 1; e_dd = (idx == BLK - 1); end
          else       begin e_iv = 1; e_id = (idx == BLK - 1); end
        end
      end
    end
    chk("mem_en", mem_en, e_en);
    chk("mem_wr", mem_wr, e_wr);
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
    chk("i_data_valid", i_data_valid, e_iv);
    chk("d_data_valid", d_data_valid, e_dv);
    chk("i_done", i_done, e_id);
    chk("d_done", d_done, e_dd);
    if (e_iv) begin chk("i_data", i_data, e_data); chk("i_word_idx", i_word_idx, idx); end
    if (e_dv) begin chk("d_data", d_data, e_data); chk("d_word_idx", d_word_idx, idx); end

    obs_en = mem_en; obs_wr = mem_wr; obs_addr = mem_addr; obs_wdata = mem_wdata;
    obs_iv = i_data_valid; obs_dv = d_data_valid; obs_idone = i_done; obs_ddone = d_done;
    obs_iidx = i_word_idx; obs_didx = d_word_idx;

    // model transition for the coming edge
    if (rst) begin
      m_busy = 0; m_starve = 0;
    end else if (m_busy) begin
      if (m_wr || m_off == LAT + BLK - 1) m_busy = 0;
      else m_off++;
    end else if (i_req && (!d_req || m_starve == SMAX)) begin
      m_busy = 1; m_own = 0; m_wr = 0; m_off = 0; m_starve = 0;
      m_base = 16'((int'(i_addr) / BLK) * BLK);
    end else if (d_req) begin
      m_busy = 1; m_own = 1; m_wr = d_we; m_off = 0; m_wdata = d_wdata;
      m_base = d_we ? d_addr : 16'((int'(d_addr) / BLK) * BLK);
      m_starve = i_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    end

    // memory environment
    if (mem_en && mem_wr) mem_a[int'(mem_addr)] = mem_wdata;
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = mem_en && !mem_wr;
    pipe_a[0] = mem_addr;

    @(posedge clk);
    #1;
    mem_rdata = pipe_v[LAT-1] ? mem_rd(pipe_a[LAT-1]) : 16'($urandom);
    cycle++;

    // requesters react to done
    if (obs_idone) begin
      order_q.push_back(8'h49);
      if (i_left > 0) i_left--;
      if (i_left == 0) i_req = 0;
      else if (rnd) i_addr = 16'($urandom);
    end
    if (obs_ddone) begin
      order_q.push_back(8'h44);
      if (d_left > 0) d_left--;
      if (d_left == 0) d_req = 0;
      else begin
        d_wdata = 16'($urandom);
        if (rnd) begin d_addr = 16'($urandom); d_we = 1'($urandom_range(1)); end
      end
    end
  endtask

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    int k, first_iv, done_k, done_idx, dact, cnt, first_idx, n;
    for (int i = 0; i < LAT; i++) begin pipe_v[i] = 0; pipe_a[i] = 0; end
    mem_rdata = 0;
    d_wdata = 0;

    // reset with both requests up, then contention: D fill first
    rst = 1; i_req = 1; i_addr = 16'h1234; i_left = 1;
    d_req = 1; d_we = 0; d_addr = 16'h0040; d_left = 1;
    repeat (2) begin
      cyc();
      chk("rst_mem_en", obs_en, 0);
      chk("rst_valid_done", obs_iv | obs_dv | obs_idone | obs_ddone, 0);
    end
    rst = 0;
    cyc();
    chk("post_rst_idle", obs_en, 0);
    cyc();
    chk("first_issue", {obs_en, obs_wr, obs_addr}, {1'b1, 1'b0, 16'h0040});
    n = 0;
    while (!obs_ddone && n < 40) begin cyc(); n++; end
    chk("contention_d_done", obs_ddone, 1);
    chk("contention_d_idx", obs_didx, 7);
    cyc();
    chk("gap_idle", obs_en, 0);

    // I fill timing
    cyc();
    k = 0; first_iv = -1; done_k = -1; done_idx = -1; dact = 0;
    while (1) begin
      if (k < BLK) chk("i_fill_addr", {obs_en, obs_addr}, {1'b1, 16'h1230 + 16'(k)});
      if (obs_iv && first_iv < 0) first_iv = k;
      if (obs_dv || obs_ddone) dact++;
      if (obs_idone) begin done_k = k; done_idx = int'(obs_iidx); break; end
      if (k >= 40) break;
      cyc();
      k++;
    end
    chk("i_first_valid_offset", first_iv, 4);
    chk("i_done_offset", done_k, 11);
    chk("i_done_idx", done_idx, 7);
    chk("i_fill_no_d_activity", dact, 0);

    // D write
    d_left = 1; d_req = 1; d_we = 1; d_addr = 16'h00A5; d_wdata = 16'hBEEF;
    n = 0;
    do begin cyc(); n++; end while (!obs_wr && n < 10);
    chk("dw_cmd", {obs_en, obs_wr, obs_addr}, {1'b1, 1'b1, 16'h00A5});
    chk("dw_wdata", obs_wdata, 16'hBEEF);
    chk("dw_done", obs_ddone, 1);

    // starvation: three back-to-back D writes against a pending I fill
    order_q.delete();
    i_left = 1; i_req = 1; i_addr = 16'h2000;
    d_left = 3; d_req = 1; d_we = 1; d_addr = 16'h0055; d_wdata = 16'h1111;
    n = 0;
    while ((i_left > 0 || d_left > 0) && n < 100) begin cyc(); n++; end
    chk("starve_len", order_q.size(), 4);
    if (order_q.size() == 4) begin
      chk("starve_g0", order_q[0], 8'h44);
      chk("starve_g1", order_q[1], 8'h44);
      chk("starve_g2", order_q[2], 8'h49);
      chk("starve_g3", order_q[3], 8'h44);
    end

    // reset in the middle of an I fill
    i_left = 1; i_req = 1; i_addr = 16'h3000;
    n = 0;
    do begin cyc(); n++; end while (!(obs_iv && obs_iidx == 3'd2) && n < 40);
    chk("midfill_idx2_seen", {obs_iv, obs_iidx}, {1'b1, 3'd2});
    rst = 1; i_req = 0; i_left = 0;
    cyc();
    rst = 0;
    cnt = 0;
    repeat (20) begin cyc(); cnt += int'(obs_iv | obs_idone); end
    chk("midfill_no_i_after_rst", cnt, 0);
    d_left = 1; d_req = 1; d_we = 0; d_addr = 16'h0100;
    cnt = 0; first_idx = -1; n = 0;
    while (n < 40) begin
      cyc(); n++;
      if (obs_dv) begin
        if (first_idx < 0) first_idx = int'(obs_didx);
        cnt++;
      end
      if (obs_ddone) break;
    end
    chk("post_rst_dfill_words", cnt, 8);
    chk("post_rst_dfill_first_idx", first_idx, 0);

    // randomized traffic
    rnd = 1;
    for (int c = 0; c < 4000; c++) begin
      if (i_left == 0 && $urandom_range(3) == 0) begin
        i_left = $urandom_range(1, 2); i_req = 1; i_addr = 16'($urandom);
      end
      if (d_left == 0 && $urandom_range(3) == 0) begin
        d_left = $urandom_range(1, 3); d_req = 1; d_we = 1'($urandom_range(1));
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if ($urandom_range(999) == 0) begin
        rst = 1; i_req = 0; d_req = 0; i_left = 0; d_left = 0;
        cyc();
        rst = 0;
      end else begin
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
